// File: rtl/audio_mixer_tdm_if.sv
// Bus bundle for audio_mixer_tdm: source samples, frame request, gain
// write port, mixed PCM results, status flags and sigma-delta bitstreams.
interface audio_mixer_tdm_if #(
  parameter int unsigned CHANNELS = 12,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned OUT_W    = 12
);
  logic [CHANNELS*SAMPLE_W-1:0] ch_data;
  logic [CHANNELS-1:0]          ch_en;
  logic                         sample_stb;
  logic                         mono;
  logic                         cfg_we;
  logic [$clog2(CHANNELS)-1:0]  cfg_addr;
  logic [7:0]                   cfg_data;
  logic                         busy;
  logic [OUT_W-1:0]             pcm_l;
  logic [OUT_W-1:0]             pcm_r;
  logic                         pcm_valid;
  logic                         clip;
  logic                         overrun;
  logic                         dac_l;
  logic                         dac_r;

  modport master (
    output ch_data, ch_en, sample_stb, mono, cfg_we, cfg_addr, cfg_data,
    input  busy, pcm_l, pcm_r, pcm_valid, clip, overrun, dac_l, dac_r
  );

  modport slave (
    input  ch_data, ch_en, sample_stb, mono, cfg_we, cfg_addr, cfg_data,
    output busy, pcm_l, pcm_r, pcm_valid, clip, overrun, dac_l, dac_r
  );
endinterface

// File: rtl/audio_mixer_tdm.sv
// Time-multiplexed stereo audio mixer: one source channel per clock,
// per-channel 4-bit L/R gains (8 = unity), saturating PCM latch with
// optional mono fold-down, and first-order sigma-delta DAC bitstreams.
// Optional feature: define AUDIO_MIXER_DITHER_EN to add 2-bit LFSR dither
// to the sigma-delta inputs.
module audio_mixer_tdm #(
  parameter int unsigned CHANNELS = 12,
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned OUT_W    = 12
) (
  input  logic               clk28,
  input  logic               rst,
  audio_mixer_tdm_if.slave   bus
);

  localparam int unsigned IW = $clog2(CHANNELS);
  localparam int unsigned AW = SAMPLE_W + 2 + IW;
  localparam int unsigned CW = (AW + 1 > OUT_W) ? AW + 1 : OUT_W;
  localparam int unsigned PW = SAMPLE_W + 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(CHANNELS - 1);
  localparam logic [CW-1:0] PCM_MAX  = CW'({OUT_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_LATCH} state_t;

  state_t state, state_nx;

  logic [IW-1:0]                idx;
  logic [AW-1:0]                acc_l, acc_r;
  logic [CHANNELS*SAMPLE_W-1:0] snap_data;
  logic [CHANNELS-1:0]          snap_en;
  logic [3:0]                   vol_l [CHANNELS];
  logic [3:0]                   vol_r [CHANNELS];
  logic [OUT_W-1:0]             pcm_l_q, pcm_r_q;
  logic                         pcm_valid_q, clip_q, overrun_q;

  logic [SAMPLE_W-1:0]          smp;
  logic [PW-1:0]                prod_l, prod_r;
  logic [AW-1:0]                add_l, add_r;
  logic [AW:0]                  sum_m;
  logic [CW-1:0]                lat_l, lat_r;
  logic                         sat_l, sat_r;
  logic [OUT_W-1:0]             pcm_l_nx, pcm_r_nx;

  logic [OUT_W-1:0]             sd_in_l, sd_in_r;
  logic [OUT_W:0]               sd_l, sd_r;

  // State register
  always_ff @(posedge clk28) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: one frame walks every channel, then latches
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (bus.sample_stb) state_nx = S_ACCUM;
      S_ACCUM: if (idx == LAST_IDX) state_nx = S_LATCH;
      S_LATCH: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-channel scaled contribution and the saturating latch values
  always_comb begin
    smp    = snap_data[32'(idx) * SAMPLE_W +: SAMPLE_W];
    prod_l = PW'(smp) * PW'(vol_l[idx]);
    prod_r = PW'(smp) * PW'(vol_r[idx]);
    add_l  = '0;
    add_r  = '0;
    if (snap_en[idx]) begin
      add_l = AW'(prod_l >> 3);
      add_r = AW'(prod_r >> 3);
    end
    sum_m = ({1'b0, acc_l} + {1'b0, acc_r}) >> 1;
    if (bus.mono) begin
      lat_l = CW'(sum_m);
      lat_r = CW'(sum_m);
    end else begin
      lat_l = CW'(acc_l);
      lat_r = CW'(acc_r);
    end
    sat_l    = (lat_l > PCM_MAX);
    sat_r    = (lat_r > PCM_MAX);
    pcm_l_nx = sat_l ? '1 : lat_l[OUT_W-1:0];
    pcm_r_nx = sat_r ? '1 : lat_r[OUT_W-1:0];
  end

  // Gain registers; out-of-range addresses are dropped
  always_ff @(posedge clk28) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        vol_l[i] <= 4'd8;
        vol_r[i] <= 4'd8;
      end
    end else if (bus.cfg_we && (32'(bus.cfg_addr) < CHANNELS)) begin
      vol_l[bus.cfg_addr] <= bus.cfg_data[7:4];
      vol_r[bus.cfg_addr] <= bus.cfg_data[3:0];
    end
  end

  // Frame datapath: snapshot, accumulate, latch, sticky status
  always_ff @(posedge clk28) begin
    if (rst) begin
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      snap_data   <= '0;
      snap_en     <= '0;
      pcm_l_q     <= '0;
      pcm_r_q     <= '0;
      pcm_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pcm_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.sample_stb) begin
            snap_data <= bus.ch_data;
            snap_en   <= bus.ch_en;
            acc_l     <= '0;
            acc_r     <= '0;
            idx       <= '0;
          end
        end
        S_ACCUM: begin
          acc_l <= acc_l + add_l;
          acc_r <= acc_r + add_r;
          idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
        S_LATCH: begin
          pcm_l_q     <= pcm_l_nx;
          pcm_r_q     <= pcm_r_nx;
          pcm_valid_q <= 1'b1;
          if (sat_l || sat_r) clip_q <= 1'b1;
        end
        default: ;
      endcase
      if (bus.sample_stb && (state != S_IDLE)) overrun_q <= 1'b1;
    end
  end

`ifdef AUDIO_MIXER_DITHER_EN
  logic [15:0]    lfsr;
  logic [OUT_W:0] dith_l, dith_r;

  // Maximal 16-bit LFSR, taps 16/14/13/11
  always_ff @(posedge clk28) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Dithered modulator input, saturating at full scale
  always_comb begin
    dith_l  = {1'b0, pcm_l_q} + (OUT_W+1)'(lfsr[1:0]);
    dith_r  = {1'b0, pcm_r_q} + (OUT_W+1)'(lfsr[1:0]);
    sd_in_l = dith_l[OUT_W] ? '1 : dith_l[OUT_W-1:0];
    sd_in_r = dith_r[OUT_W] ? '1 : dith_r[OUT_W-1:0];
  end
`else
  assign sd_in_l = pcm_l_q;
  assign sd_in_r = pcm_r_q;
`endif

  // First-order sigma-delta: carry out of the residue is the bitstream
  always_ff @(posedge clk28) begin
    if (rst) begin
      sd_l <= '0;
      sd_r <= '0;
    end else begin
      sd_l <= {1'b0, sd_l[OUT_W-1:0]} + {1'b0, sd_in_l};
      sd_r <= {1'b0, sd_r[OUT_W-1:0]} + {1'b0, sd_in_r};
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.pcm_l     = pcm_l_q;
  assign bus.pcm_r     = pcm_r_q;
  assign bus.pcm_valid = pcm_valid_q;
  assign bus.clip      = clip_q;
  assign bus.overrun   = overrun_q;
  assign bus.dac_l     = sd_l[OUT_W];
  assign bus.dac_r     = sd_r[OUT_W];

endmodule

// File: tb/tb_audio_mixer_tdm.sv
// Self-checking bench for audio_mixer_tdm (default parameters, dither off).
module tb_audio_mixer_tdm;

  logic clk28 = 1'b0;
  logic rst   = 1'b1;

  audio_mixer_tdm_if #(.CHANNELS(12), .SAMPLE_W(8), .OUT_W(12)) bus ();

  audio_mixer_tdm #(.CHANNELS(12), .SAMPLE_W(8), .OUT_W(12)) dut (
    .clk28 (clk28),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk28 = ~clk28;

  typedef struct {
    logic [11:0] l;
    logic [11:0] r;
  } exp_t;

  typedef struct {
    logic [95:0] data;
    logic [11:0] en;
    logic [3:0]  vl;
    logic [3:0]  vr;
    logic        mono;
    logic [11:0] el;
    logic [11:0] er;
    logic        eclip;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[9];
  int          errors   = 0;
  int          checks   = 0;
  int          pv_count = 0;
  logic [3:0]  gl [12];
  logic [3:0]  gr [12];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  // Scoreboard: every pcm_valid pulse must match the oldest expected frame
  always @(negedge clk28) begin
    if (!rst && bus.pcm_valid) begin
      exp_t e;
      pv_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pcm_frame: unexpected pcm_valid l=%0d r=%0d", bus.pcm_l, bus.pcm_r);
      end else begin
        e = exp_q.pop_front();
        if (bus.pcm_l !== e.l || bus.pcm_r !== e.r) begin
          errors++;
          $display("FAIL pcm_frame: got l=%0d r=%0d expected l=%0d r=%0d",
                   bus.pcm_l, bus.pcm_r, e.l, e.r);
        end
      end
    end
  end

  task automatic set_gain(input int unsigned a, input logic [3:0] vl, input logic [3:0] vr);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = 4'(a);
    bus.cfg_data = {vl, vr};
    tick();
    bus.cfg_we   = 1'b0;
    if (a < 12) begin
      gl[a] = vl;
      gr[a] = vr;
    end
  endtask

  task automatic set_all(input logic [3:0] vl, input logic [3:0] vr);
    for (int k = 0; k < 12; k++) set_gain(k, vl, vr);
  endtask

  task automatic push(input logic [11:0] l, input logic [11:0] r);
    exp_t e;
    e.l = l;
    e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic pulse_stb();
    bus.sample_stb = 1'b1;
    tick();
    bus.sample_stb = 1'b0;
  endtask

  // Bounded wait for the frame result, then step past the monitor sample
  task automatic wait_done();
    int n = 0;
    while (!bus.pcm_valid && n < 40) begin
      tick();
      n++;
    end
    if (!bus.pcm_valid) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no pcm_valid expected pcm_valid within 40 cycles");
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    tick();
  endtask

  task automatic run_frame(input logic [11:0] l, input logic [11:0] r);
    push(l, r);
    pulse_stb();
    wait_done();
  endtask

  function automatic void model(input logic [95:0] d, input logic [11:0] en, input logic m,
                                output logic [11:0] l, output logic [11:0] r);
    int unsigned al = 0;
    int unsigned ar = 0;
    for (int k = 0; k < 12; k++) begin
      if (en[k]) begin
        al += (int'(d[k*8 +: 8]) * int'(gl[k])) / 8;
        ar += (int'(d[k*8 +: 8]) * int'(gr[k])) / 8;
      end
    end
    if (m) begin
      al = (al + ar) / 2;
      ar = al;
    end
    l = (al > 4095) ? 12'd4095 : 12'(al);
    r = (ar > 4095) ? 12'd4095 : 12'(ar);
  endfunction

  initial begin
    int          cnt;
    int          pv0;
    int          ones_l;
    int          ones_r;
    logic [95:0] d;
    logic [11:0] en, el, er;
    logic        m;

    vecs[0] = '{96'd200, 12'hFFF, 4'd8, 4'd8, 1'b0, 12'd200, 12'd200, 1'b0};
    vecs[1] = '{{80'd0, 8'd100, 8'd0}, 12'hFFF, 4'd8, 4'd0, 1'b1, 12'd50, 12'd50, 1'b0};
    vecs[2] = '{{80'd0, 8'd100, 8'd0}, 12'hFFF, 4'd8, 4'd0, 1'b0, 12'd100, 12'd0, 1'b0};
    vecs[3] = '{{12{8'd10}}, 12'h00F, 4'd8, 4'd8, 1'b0, 12'd40, 12'd40, 1'b0};
    vecs[4] = '{{8'd77, 88'd0}, 12'hFFF, 4'd15, 4'd1, 1'b0, 12'd144, 12'd9, 1'b0};
    vecs[5] = '{{8'd77, 88'd0}, 12'h7FF, 4'd15, 4'd1, 1'b0, 12'd0, 12'd0, 1'b0};
    vecs[6] = '{{12{8'd255}}, 12'hFFF, 4'd8, 4'd8, 1'b1, 12'd3060, 12'd3060, 1'b0};
    vecs[7] = '{{12{8'd255}}, 12'hFFF, 4'd15, 4'd15, 1'b0, 12'd4095, 12'd4095, 1'b1};
    vecs[8] = '{{12{8'd255}}, 12'hFFF, 4'd4, 4'd4, 1'b0, 12'd1524, 12'd1524, 1'b1};

    for (int k = 0; k < 12; k++) begin
      gl[k] = 4'd8;
      gr[k] = 4'd8;
    end
    bus.ch_data    = '0;
    bus.ch_en      = '1;
    bus.sample_stb = 1'b0;
    bus.mono       = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("reset_busy", bus.busy, 0);
    check("reset_pcm_valid", bus.pcm_valid, 0);
    check("reset_pcm_l", bus.pcm_l, 0);
    check("reset_clip", bus.clip, 0);
    check("reset_overrun", bus.overrun, 0);
    check("reset_dac_l", bus.dac_l, 0);

    // Latency and busy window of a single frame
    bus.ch_data = 96'd200;
    push(12'd200, 12'd200);
    pulse_stb();
    cnt = 1;
    check("busy_after_stb", bus.busy, 1);
    while (!bus.pcm_valid && cnt < 40) begin
      tick();
      cnt++;
      if (cnt == 13) check("busy_in_latch", bus.busy, 1);
    end
    check("valid_latency", cnt, 14);
    check("busy_at_valid", bus.busy, 0);
    tick();

    // Table-driven frames
    for (int i = 0; i < 9; i++) begin
      set_all(vecs[i].vl, vecs[i].vr);
      bus.ch_data = vecs[i].data;
      bus.ch_en   = vecs[i].en;
      bus.mono    = vecs[i].mono;
      run_frame(vecs[i].el, vecs[i].er);
      check($sformatf("clip_vec%0d", i), bus.clip, vecs[i].eclip);
    end
    bus.mono  = 1'b0;
    bus.ch_en = '1;

    // Random frames against the bench model
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 12; k++) set_gain(k, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      d  = {$urandom, $urandom, $urandom};
      en = 12'($urandom);
      m  = 1'($urandom);
      bus.ch_data = d;
      bus.ch_en   = en;
      bus.mono    = m;
      model(d, en, m, el, er);
      run_frame(el, er);
    end
    bus.ch_en = '1;
    bus.mono  = 1'b0;

    // Gain writes during ACCUM only touch unprocessed channels
    set_all(4'd8, 4'd8);
    bus.ch_data = {12{8'd100}};
    push(12'd1100, 12'd1100);
    pulse_stb();
    repeat (2) tick();
    set_gain(0, 4'd0, 4'd0);
    set_gain(11, 4'd0, 4'd0);
    wait_done();
    set_gain(13, 4'd0, 4'd0);
    run_frame(12'd1000, 12'd1000);

    // mono is taken at LATCH, not at the strobe
    set_all(4'd8, 4'd8);
    set_gain(0, 4'd8, 4'd0);
    bus.ch_data = 96'd100;
    bus.mono    = 1'b1;
    push(12'd100, 12'd0);
    pulse_stb();
    repeat (2) tick();
    bus.mono = 1'b0;
    wait_done();
    push(12'd50, 12'd50);
    pulse_stb();
    repeat (11) tick();
    bus.mono = 1'b1;
    wait_done();
    bus.mono = 1'b0;

    // Overlapping strobe: one result, sticky overrun
    set_gain(0, 4'd8, 4'd8);
    check("overrun_before", bus.overrun, 0);
    bus.ch_data = 96'd200;
    pv0 = pv_count;
    push(12'd200, 12'd200);
    pulse_stb();
    repeat (2) tick();
    pulse_stb();
    check("overrun_set", bus.overrun, 1);
    wait_done();
    repeat (30) tick();
    check("overrun_single_valid", pv_count - pv0, 1);
    check("overrun_sticky", bus.overrun, 1);

    // Sigma-delta density at pcm=1024
    bus.ch_data = {32'd0, {8{8'd128}}};
    run_frame(12'd1024, 12'd1024);
    repeat (2) tick();
    ones_l = 0;
    ones_r = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      ones_l += int'(bus.dac_l);
      ones_r += int'(bus.dac_r);
    end
    check("sd_ones_l", ones_l, 1024);
    check("sd_ones_r", ones_r, 1024);

    // Reset in the middle of ACCUM
    set_gain(0, 4'd3, 4'd5);
    bus.ch_data = 96'd200;
    pulse_stb();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      gl[k] = 4'd8;
      gr[k] = 4'd8;
    end
    pv0 = pv_count;
    repeat (20) tick();
    check("rst_mid_no_valid", pv_count - pv0, 0);
    check("rst_mid_pcm_l", bus.pcm_l, 0);
    check("rst_mid_pcm_r", bus.pcm_r, 0);
    check("rst_mid_clip", bus.clip, 0);
    check("rst_mid_overrun", bus.overrun, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_dac_l", bus.dac_l, 0);
    run_frame(12'd200, 12'd200);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_mixer_tdm.md
AUDIO_MIXER_TDM -- requirements
Module: audio_mixer_tdm

Interface
REQ-001 SHALL have parameter CHANNELS, default 12, number of mixed sources (legal 2..32).
REQ-002 SHALL have parameter SAMPLE_W, default 8, unsigned sample width per source.
REQ-003 SHALL have parameter OUT_W, default 12, PCM result and sigma-delta width.
REQ-004 SHALL have port clk28  in  1  system clock; single clock domain.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port ch_data  in  CHANNELS*SAMPLE_W  packed unsigned samples; channel k at bits [k*SAMPLE_W +: SAMPLE_W].
REQ-007 SHALL have port ch_en  in  CHANNELS  per-channel enable; 0 contributes zero.
REQ-008 SHALL have port sample_stb  in  1  single-cycle request to mix one frame.
REQ-009 SHALL have port mono  in  1  mono mode select.
REQ-010 SHALL have ports cfg_we  in  1, cfg_addr  in  $clog2(CHANNELS), cfg_data  in  8  ({vol_l[3:0], vol_r[3:0]}), all gain write port.
REQ-011 SHALL have port busy  out  1  high while a frame is in progress.
REQ-012 SHALL have ports pcm_l, pcm_r  out  OUT_W  last mixed frame, unsigned.
REQ-013 SHALL have port pcm_valid  out  1  one-cycle pulse when pcm_l/pcm_r update.
REQ-014 SHALL have ports clip  out  1 and overrun  out  1, both sticky status flags.
REQ-015 SHALL have ports dac_l, dac_r  out  1  first-order sigma-delta bitstreams.

Function
REQ-016 SHALL implement FSM IDLE -> ACCUM -> LATCH -> IDLE.
REQ-017 In IDLE, sample_stb=1 SHALL snapshot ch_data and ch_en, clear both accumulators, set index=0, and enter ACCUM.
REQ-018 ACCUM SHALL process one channel per cycle, index 0..CHANNELS-1, and SHALL enter LATCH after index CHANNELS-1.
REQ-019 Per channel, acc_l SHALL add (sample*vol_l)>>3 and acc_r SHALL add (sample*vol_r)>>3; vol=8 is unity, vol=0 mutes, vol=15 is 1.875x.
REQ-020 Accumulators SHALL be SAMPLE_W+2+$clog2(CHANNELS) bits wide and SHALL never wrap.
REQ-021 In LATCH, stereo mode SHALL set pcm_x = min(acc_x, 2^OUT_W-1); mono mode SHALL set pcm_l = pcm_r = min((acc_l+acc_r)>>1, 2^OUT_W-1).
REQ-022 Any saturation in LATCH SHALL set clip.
REQ-023 pcm_valid SHALL pulse in the cycle after LATCH, so stb accepted at cycle T gives pcm_valid at T+CHANNELS+2.
REQ-024 busy SHALL be high from the cycle after accepting stb through LATCH inclusive.
REQ-025 sample_stb while not IDLE SHALL be ignored and SHALL set overrun; the frame in progress SHALL be unaffected.
REQ-026 A gain write (cfg_we=1) SHALL update the gain registers at the next edge.
REQ-027 A gain write during ACCUM SHALL affect only channels not yet processed in the current frame.
REQ-028 A gain write with cfg_addr >= CHANNELS SHALL be ignored.
REQ-029 The mono input SHALL be sampled in LATCH only.
REQ-030 Sigma-delta SHALL update every cycle: sd_x <= sd_x[OUT_W-1:0] + pcm_x, with dac_x = sd_x[OUT_W] registered; ones density SHALL equal pcm_x/2^OUT_W.

Reset
REQ-031 Reset SHALL drive the FSM to IDLE and clear index and both accumulators.
REQ-032 Reset SHALL zero pcm_l, pcm_r, pcm_valid, busy, clip, overrun, dac_l, dac_r, and the sigma-delta accumulators.
REQ-033 Reset SHALL set all gains to 8/8.
REQ-034 Reset mid-frame SHALL abandon the frame without producing pcm_valid.
REQ-035 clip and overrun SHALL clear only on reset.

Configuration
REQ-036 With AUDIO_MIXER_DITHER_EN defined, a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, nonzero seed after reset) SHALL step every cycle, and its 2 LSBs SHALL be added to pcm_x in the sigma-delta input, saturating at 2^OUT_W-1.
REQ-037 Without AUDIO_MIXER_DITHER_EN, the block SHALL contain no LFSR, and the sigma-delta input SHALL be exactly pcm_x.

Verification
REQ-038 Channel 0=200, others 0, gains 8/8, stb -> pcm_l=pcm_r=200 and pcm_valid exactly 14 cycles after stb.
REQ-039 All 12 channels=255, gains 15/15 -> pcm_l=pcm_r=4095 and clip=1; the same frame with gains 4/4 -> 1524 on both, with clip still 1.
REQ-040 Channel 1=100 with vol_l=8, vol_r=0, mono=1 -> pcm_l=pcm_r=50; the same with mono=0 -> pcm_l=100, pcm_r=0.
REQ-041 Second stb 3 cycles after the first -> overrun=1, exactly one pcm_valid, and result equal to a single frame.
REQ-042 pcm_l=1024 held for 4096 cycles, dither off -> exactly 1024 ones on dac_l.
REQ-043 rst asserted at ACCUM index 5 -> no pcm_valid, all outputs 0, gains 8/8, and the next stb mixes normally.
